// File: rtl/aucohl_uart_rx.sv
// UART receiver: 16x oversampling, mid-bit sampling, optional parity.
// Completed words are pushed into a downstream FIFO through a wr/wdata/full interface.
module aucohl_uart_rx #(
  parameter int DW = 8,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          rx,
  input  logic [W-1:0]  clk_div,
  input  logic          parity_en,
  input  logic          parity_odd,
  input  logic          fifo_full,
  output logic          wr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          frame_err,
  output logic          parity_err,
  output logic          overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [W-1:0]  p_q, p_d;
  logic [3:0]    s_q, s_d;
  logic [3:0]    b_q, b_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          par_q, par_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;
  logic          ov_q, ov_d;
  logic          tick;
  logic          fall;

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s2_q;
  assign tick = en & (p_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = tick ? clk_div : p_q - W'(1);
    s_d     = tick ? s_q + 4'd1 : s_q;
    b_d     = b_q;
    sh_d    = sh_q;
    par_d   = par_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          p_d     = clk_div;
          s_d     = 4'd0;
        end
      end
      START: begin
        if (tick && s_q == 4'd7) begin
          if (!rx_s2_q) begin
            state_d = DATA;
            s_d     = 4'd0;
            b_d     = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && s_q == 4'd15) begin
          sh_d = {rx_s2_q, sh_q[DW-1:1]};
          b_d  = b_q + 4'd1;
          s_d  = 4'd0;
          if (b_q == 4'(DW - 1)) begin
            state_d = parity_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick && s_q == 4'd15) begin
          par_d   = rx_s2_q;
          state_d = STOP;
          s_d     = 4'd0;
        end
      end
      STOP: begin
        // Return to IDLE mid stop bit so a back-to-back start edge is not missed.
        if (tick && s_q == 4'd15) begin
          state_d = IDLE;
          s_d     = 4'd0;
          fe_d    = ~rx_s2_q;
          pe_d    = parity_en & ((^sh_q) ^ par_q ^ parity_odd);
          if (fifo_full) begin
            ov_d = 1'b1;
          end else begin
            wr_d    = 1'b1;
            wdata_d = sh_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      s_d     = 4'd0;
      p_d     = '0;
      wr_d    = 1'b0;
      fe_d    = 1'b0;
      pe_d    = 1'b0;
      ov_d    = 1'b0;
    end
  end

  assign wr         = wr_q;
  assign wdata      = wdata_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_aucohl_uart_rx.sv
// Scoreboard bench for aucohl_uart_rx: frames are queued with their expected
// completion record, and a negedge monitor pops and compares each DUT completion.
module tb_aucohl_uart_rx;

  localparam int DW = 8;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rx;
  logic [W-1:0]  clk_div;
  logic          parity_en;
  logic          parity_odd;
  logic          fifo_full;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  aucohl_uart_rx #(.DW(DW), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rx         (rx),
    .clk_div    (clk_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .fifo_full  (fifo_full),
    .wr         (wr),
    .wdata      (wdata),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       wrExp;
    logic       frameErr;
    logic       parityErr;
    logic       overrun;
  } expT;

  expT        expQ[$];
  expT        monE;
  int         errorCount  = 0;
  int         checkCount  = 0;
  int         cycleCnt    = 0;
  int         busyRise    = 0;
  int         lastLatency = -1;
  int         wrCount     = 0;
  int         bitClocks   = 16;
  logic [7:0] lastWritten = 8'h00;
  logic       busyPrev    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycleCnt++;

  // Monitor: every completion cycle is matched against the oldest queued frame.
  always @(negedge clk) begin
    if (busy && !busyPrev) busyRise = cycleCnt;
    busyPrev = busy;
    if (wr || overrun || frame_err || parity_err) begin
      if (wr) begin
        wrCount++;
        lastLatency = cycleCnt - busyRise;
      end
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected completion: wr=%0b wdata=0x%0h fe=%0b pe=%0b ov=%0b, expected none",
                 wr, wdata, frame_err, parity_err, overrun);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr", 32'(wr), 32'(monE.wrExp));
        checkOutput("wdata", 32'(wdata), 32'(monE.data));
        checkOutput("frame_err", 32'(frame_err), 32'(monE.frameErr));
        checkOutput("parity_err", 32'(parity_err), 32'(monE.parityErr));
        checkOutput("overrun", 32'(overrun), 32'(monE.overrun));
      end
    end
  end

  task automatic driveBit(input logic b);
    rx = b;
    repeat (bitClocks) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic withPar, input logic parBit,
                               input logic stopBit, input logic expFe, input logic expPe,
                               input int idleBits);
    expT e;
    e.overrun   = fifo_full;
    e.wrExp     = ~fifo_full;
    e.data      = fifo_full ? lastWritten : d;
    e.frameErr  = expFe;
    e.parityErr = expPe;
    if (!fifo_full) lastWritten = d;
    expQ.push_back(e);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (withPar) driveBit(parBit);
    driveBit(stopBit);
    for (int i = 0; i < idleBits; i++) driveBit(1'b1);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    int busyCycles;
    rst_n      = 1'b0;
    en         = 1'b0;
    rx         = 1'b1;
    clk_div    = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    fifo_full  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_wr", 32'(wr), 32'd0);
    checkOutput("reset_wdata", 32'(wdata), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 at 16 clocks per bit; wr lands 8+16*9 ticks after the start edge.
    bitClocks = 16;
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(200);
    checkOutput("t1_latency", 32'(lastLatency), 32'd152);
    checkOutput("t1_wrCount", 32'(wrCount), 32'd1);
    checkOutput("t1_busyIdle", 32'(busy), 32'd0);

    // Even parity on 0x3C needs bit 0; then odd parity on 0x07 needs bit 0.
    clk_div   = 16'd3;
    bitClocks = 64;
    parity_en = 1'b1;
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2);
    waitDrain(400);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(400);
    parity_odd = 1'b1;
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(400);

    // Stop bit 0 then line held low: one frame error, nothing more.
    clk_div    = '0;
    bitClocks  = 16;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    n0 = wrCount;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    repeat (3 * 160) @(negedge clk);
    waitDrain(200);
    checkOutput("t3_wrCount", 32'(wrCount), 32'(n0 + 1));
    rx = 1'b1;
    repeat (32) @(negedge clk);

    // Four-clock glitch is rejected at the mid start bit check.
    n0 = wrCount;
    busyCycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) busyCycles++;
    end
    checkOutput("t4_busyCycles", 32'(busyCycles), 32'd8);
    checkOutput("t4_noWr", 32'(wrCount), 32'(n0));

    // Overrun keeps the old word; then two back-to-back frames.
    fifo_full = 1'b1;
    n0 = wrCount;
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(200);
    checkOutput("t5_noWr", 32'(wrCount), 32'(n0));
    fifo_full = 1'b0;
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(200);
    checkOutput("t5_wrCount", 32'(wrCount), 32'(n0 + 2));

    // Disable mid-DATA, then a clean frame.
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    en = 1'b0;
    @(negedge clk);
    checkOutput("t6_abortIdle", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    waitDrain(200);

    // Asynchronous reset mid-frame.
    n0 = wrCount;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    #3;
    checkOutput("t7_busyBefore", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_busy", 32'(busy), 32'd0);
    checkOutput("t7_wr", 32'(wr), 32'd0);
    checkOutput("t7_wdata", 32'(wdata), 32'd0);
    checkOutput("t7_errs", 32'({frame_err, parity_err, overrun}), 32'd0);
    @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("t7_noWr", 32'(wrCount), 32'(n0));
    checkOutput("final_queue", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
